// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core (C) and debug (D) requesters, the data memory and dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [2:0]        c_funct3;
    logic              c_gnt;
    logic              c_rvalid;
    logic [31:0]       c_rdata;
    logic              c_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [2:0]        d_funct3;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        input  d_req, d_we, d_addr, d_wdata, d_funct3,
        input  mem_rdata,
        output c_gnt, c_rvalid, c_rdata, c_stall,
        output d_gnt, d_rvalid, d_rdata,
        output mem_wr, mem_rd, mem_addr, mem_wdata, mem_funct3
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        output d_req, d_we, d_addr, d_wdata, d_funct3,
        output mem_rdata,
        input  c_gnt, c_rvalid, c_rdata, c_stall,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_wr, mem_rd, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory: one transaction in flight,
// fixed-latency reads, core stall generation and starvation relief for the debug port.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int READ_LAT     = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(READ_LAT - 1);
    localparam logic [3:0] STARVE_THR = 4'(STARVE_LIMIT);

    state_t      r_state;
    logic [2:0]  r_lat_cnt;
    logic [3:0]  r_starve_cnt;
    logic        r_owner_d;
    logic        r_c_rvalid;
    logic        r_d_rvalid;
    logic [31:0] r_c_rdata;
    logic [31:0] r_d_rdata;

    logic              w_arb_en;
    logic              w_d_priority;
    logic              w_c_gnt;
    logic              w_d_gnt;
    logic              w_any_gnt;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_addr;

    // Grants are decided in the same cycle the request is seen; RD_WAIT blocks everyone.
    assign w_arb_en     = (r_state != RD_WAIT);
    assign w_d_priority = (r_starve_cnt >= STARVE_THR);
    assign w_c_gnt      = w_arb_en & bus.c_req & ~(bus.d_req & w_d_priority);
    assign w_d_gnt      = w_arb_en & bus.d_req & ~w_c_gnt;
    assign w_any_gnt    = w_c_gnt | w_d_gnt;
    assign w_gnt_we     = w_d_gnt ? bus.d_we : bus.c_we;
    assign w_addr       = w_d_gnt ? bus.d_addr : bus.c_addr;

    assign bus.c_gnt      = w_c_gnt;
    assign bus.d_gnt      = w_d_gnt;
    assign bus.mem_wr     = w_any_gnt & w_gnt_we;
    assign bus.mem_rd     = w_any_gnt & ~w_gnt_we;
    assign bus.mem_addr   = w_addr;
    assign bus.mem_wdata  = w_d_gnt ? bus.d_wdata : bus.c_wdata;
    assign bus.mem_funct3 = w_d_gnt ? bus.d_funct3 : bus.c_funct3;

    assign bus.c_rvalid = r_c_rvalid;
    assign bus.d_rvalid = r_d_rvalid;
    assign bus.c_rdata  = r_c_rdata;
    assign bus.d_rdata  = r_d_rdata;

    // A granted store or the load-completion cycle releases the core.
    assign bus.c_stall = bus.c_req & ~(w_c_gnt & bus.c_we) & ~r_c_rvalid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_lat_cnt    <= 3'd0;
            r_starve_cnt <= 4'd0;
            r_owner_d    <= 1'b0;
            r_c_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_c_rdata    <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else begin
            r_c_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;

            if (!bus.d_req || w_d_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != 4'd15) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            case (r_state)
                IDLE, RD_DONE: begin
                    if (w_any_gnt && !w_gnt_we) begin
                        r_owner_d <= w_d_gnt;
                        r_lat_cnt <= LAT_LOAD;
                        r_state   <= RD_WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        // Data is captured straight into the owner's holding register.
                        if (r_owner_d) begin
                            r_d_rdata  <= bus.mem_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_c_rdata  <= bus.mem_rdata;
                            r_c_rvalid <= 1'b1;
                        end
                        r_state <= RD_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized requesters,
// compared every cycle against a timestamp-based reference model of the arbiter.
module tb_dmem_arbiter;
    localparam int ADDR_W = 12;
    localparam int LAT    = 3;
    localparam int SLIM   = 4;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .READ_LAT    (LAT),
        .STARVE_LIMIT(SLIM)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    // Reference model: memory busy windows expressed as cycle timestamps.
    int          cyc;
    int          free_at;
    int          cap_at;
    int          done_at;
    bit          rd_owner_d;
    logic [31:0] cap_val;
    logic [31:0] exp_rdata [2];
    int          starve;
    bit          last_gnt [2];
    bit          obs_cgnt;
    bit          obs_dgnt;

    // Randomized requester state, index 0 = core, 1 = debug.
    bit                p_act  [2];
    bit                p_got  [2];
    bit                p_we   [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [31:0]       p_wdata[2];
    logic [2:0]        p_f3   [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        free_at      = 0;
        cap_at       = -1;
        done_at      = -1;
        rd_owner_d   = 1'b0;
        cap_val      = 32'd0;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        starve       = 0;
        last_gnt[0]  = 1'b0;
        last_gnt[1]  = 1'b0;
    endtask

    // One clock cycle: inputs already driven at the preceding negedge.
    task automatic step();
        bit cg, dg, crv, drv, can, gwe, stall;
        #1;
        if (!n_rst) clear_model();
        can = (cyc >= free_at);
        crv = (cyc == done_at) && !rd_owner_d;
        drv = (cyc == done_at) && rd_owner_d;
        if (crv) exp_rdata[0] = cap_val;
        if (drv) exp_rdata[1] = cap_val;
        cg    = can && bus.c_req && (!bus.d_req || starve < SLIM);
        dg    = can && bus.d_req && !cg;
        gwe   = cg ? bus.c_we : bus.d_we;
        stall = bus.c_req && !(cg && bus.c_we) && !crv;

        chk("c_gnt",    32'(bus.c_gnt),    32'(cg));
        chk("d_gnt",    32'(bus.d_gnt),    32'(dg));
        chk("mem_wr",   32'(bus.mem_wr),   32'((cg || dg) && gwe));
        chk("mem_rd",   32'(bus.mem_rd),   32'((cg || dg) && !gwe));
        chk("c_rvalid", 32'(bus.c_rvalid), 32'(crv));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(drv));
        chk("c_rdata",  bus.c_rdata,       exp_rdata[0]);
        chk("d_rdata",  bus.d_rdata,       exp_rdata[1]);
        chk("c_stall",  32'(bus.c_stall),  32'(stall));
        if (cg || dg) begin
            chk("mem_addr",   32'(bus.mem_addr),   32'(cg ? bus.c_addr : bus.d_addr));
            chk("mem_wdata",  bus.mem_wdata,       cg ? bus.c_wdata : bus.d_wdata);
            chk("mem_funct3", 32'(bus.mem_funct3), 32'(cg ? bus.c_funct3 : bus.d_funct3));
        end
        obs_cgnt = bus.c_gnt;
        obs_dgnt = bus.d_gnt;

        if (n_rst) begin
            if (cyc == cap_at) cap_val = bus.mem_rdata;
            if ((cg || dg) && !gwe) begin
                cap_at     = cyc + LAT;
                done_at    = cyc + LAT + 1;
                free_at    = done_at;
                rd_owner_d = dg;
            end
            starve      = (!bus.d_req || dg) ? 0 : ((starve < 15) ? starve + 1 : 15);
            last_gnt[0] = cg;
            last_gnt[1] = dg;
        end
        $display("cyc=%0d c_req=%0b d_req=%0b c_gnt=%0b d_gnt=%0b c_rv=%0b d_rv=%0b stall=%0b",
                 cyc, bus.c_req, bus.d_req, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.c_stall);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_c(bit req, bit we, logic [ADDR_W-1:0] addr, logic [31:0] wdata, logic [2:0] f3);
        bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_funct3 = f3;
    endtask

    task automatic set_d(bit req, bit we, logic [ADDR_W-1:0] addr, logic [31:0] wdata, logic [2:0] f3);
        bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_funct3 = f3;
    endtask

    task automatic drive_ports(bit allow_new);
        for (int p = 0; p < 2; p++) begin
            if (p_act[p] && p_got[p] && (p_we[p] || (cyc == done_at && rd_owner_d == (p == 1))))
                p_act[p] = 1'b0;
            if (!p_act[p] && allow_new && $urandom_range(0, 2) != 0) begin
                p_act[p]   = 1'b1;
                p_got[p]   = 1'b0;
                p_we[p]    = ($urandom_range(0, 1) == 1);
                p_addr[p]  = ADDR_W'($urandom);
                p_wdata[p] = $urandom;
                p_f3[p]    = 3'($urandom);
            end
        end
        set_c(p_act[0], p_we[0], p_addr[0], p_wdata[0], p_f3[0]);
        set_d(p_act[1], p_we[1], p_addr[1], p_wdata[1], p_f3[1]);
        bus.mem_rdata = $urandom;
    endtask

    task automatic run_random(int n, bit allow_new);
        for (int i = 0; i < n; i++) begin
            drive_ports(allow_new);
            step();
            for (int p = 0; p < 2; p++)
                if (p_act[p] && last_gnt[p]) p_got[p] = 1'b1;
        end
    endtask

    initial begin
        int first_d;
        cyc = 0;
        clear_model();
        for (int p = 0; p < 2; p++) begin
            p_act[p] = 1'b0; p_got[p] = 1'b0; p_we[p] = 1'b0;
            p_addr[p] = '0; p_wdata[p] = '0; p_f3[p] = '0;
        end
        set_c(1'b0, 1'b0, '0, '0, '0);
        set_d(1'b0, 1'b0, '0, '0, '0);
        bus.mem_rdata = 32'd0;
        #2 n_rst = 1'b0;
        @(negedge clk);

        // Reset state
        step();
        step();
        n_rst = 1'b1;
        step();

        // Core store alone: same-cycle grant, no stall
        set_c(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 3'b010);
        step();
        chk("store_gnt", 32'(obs_cgnt), 32'd1);

        // Core load: stall through the wait, data shows in the completion cycle
        set_c(1'b1, 1'b0, 12'h020, 32'd0, 3'b010);
        for (int i = 0; i <= LAT; i++) begin
            bus.mem_rdata = (i == LAT) ? 32'h12345678 : $urandom;
            step();
        end
        set_c(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        step();
        chk("load_rdata_held", bus.c_rdata, 32'h12345678);

        // Contention: both ports store continuously
        first_d = -1;
        set_c(1'b1, 1'b1, 12'h100, 32'hC0C0C0C0, 3'b010);
        set_d(1'b1, 1'b1, 12'h200, 32'hD0D0D0D0, 3'b001);
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_dgnt && first_d < 0) first_d = i;
        end
        chk("contend_first_d", 32'(first_d), 32'd4);
        set_d(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);

        // Back-to-back: core load completes while debug store is granted
        set_c(1'b1, 1'b0, 12'h024, 32'd0, 3'b100);
        for (int i = 0; i <= LAT; i++) begin
            bus.mem_rdata = $urandom;
            step();
        end
        set_c(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        set_d(1'b1, 1'b1, 12'h300, 32'hA5A55A5A, 3'b000);
        step();
        chk("b2b_dgnt", 32'(obs_dgnt), 32'd1);
        set_d(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        step();

        // Debug load blocks a waiting core store until its completion cycle
        set_d(1'b1, 1'b0, 12'h044, 32'd0, 3'b010);
        bus.mem_rdata = $urandom;
        step();
        set_c(1'b1, 1'b1, 12'h030, 32'h0BADF00D, 3'b010);
        for (int i = 0; i < LAT; i++) begin
            bus.mem_rdata = $urandom;
            step();
        end
        set_d(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        step();
        chk("dload_then_cgnt", 32'(obs_cgnt), 32'd1);
        set_c(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        step();

        // Randomized traffic, then drain
        run_random(600, 1'b1);
        run_random(30, 1'b0);
        for (int p = 0; p < 2; p++) p_act[p] = 1'b0;
        set_c(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        set_d(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        step();

        // Reset in the middle of a read
        set_c(1'b1, 1'b0, 12'h040, 32'd0, 3'b010);
        step();
        step();
        n_rst = 1'b0;
        set_c(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        step();
        step();
        n_rst = 1'b1;
        set_c(1'b1, 1'b1, 12'h050, 32'h55AA55AA, 3'b010);
        step();
        chk("post_rst_gnt", 32'(obs_cgnt), 32'd1);
        set_c(1'b0, 1'b0, 12'h000, 32'd0, 3'b000);
        for (int i = 0; i < LAT + 2; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory (memory_reg_file) between two requesters: the RV32I core load/store path (port C) and a debug/program-loader port (port D).
- Enforces one transaction in flight and sequences a fixed-latency read.
- Drives a core stall so the PC and register file freeze while a core access is pending.
- Sits between the core's ALU_Out/rd2/funct3 datapath and the memory's MemWr/MemRead/addr/write_data/funct3 inputs.

Parameters:
- ADDR_W, 12, memory byte-address width.
- READ_LAT, 1, cycles from read issue to valid mem_rdata; legal range 1..7.
- STARVE_LIMIT, 4, consecutive denied cycles after which port D wins arbitration; legal range 1..15.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- c_req  in  1  core access request; held high until done
- c_we  in  1  1 = store, 0 = load
- c_addr  in  ADDR_W  core byte address
- c_wdata  in  32  core store data
- c_funct3  in  3  core access size/sign
- c_gnt  out  1  core request accepted this cycle
- c_rvalid  out  1  core load data valid, one-cycle pulse
- c_rdata  out  32  core load data, held until the next core read completes
- c_stall  out  1  freezes the core PC
- d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata  same directions, widths and meanings for the debug port
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  32  write data to memory
- mem_funct3  out  3  size/sign to memory
- mem_rdata  in  32  memory read data

Behaviour:
- States: IDLE, RD_WAIT, RD_DONE.
- Reset values: state IDLE, latency counter 0, starve counter 0, owner C, all gnt/rvalid/mem strobes 0, rdata outputs 0.
- Arbitration happens only in IDLE and RD_DONE, and is combinational in that cycle:
  - Only one port requesting: that port wins.
  - Both requesting: C wins unless starve_cnt >= STARVE_LIMIT, in which case D wins.
- Granted cycle:
  - The winner's gnt is 1.
  - mem_addr, mem_wdata and mem_funct3 are taken from the winner.
  - mem_wr = winner's we; mem_rd = !winner's we.
  - When nothing is granted, mem_wr = mem_rd = 0 and the other mem outputs are don't-care.
- Write: completes in the grant cycle. State stays IDLE (or goes IDLE from RD_DONE). A new grant is possible the next cycle.
- Read issued in cycle T:
  - Record the owner, load the latency counter with READ_LAT−1, go to RD_WAIT.
  - In RD_WAIT, decrement each cycle. In cycle T+READ_LAT (counter 0), mem_rdata is captured and the state moves to RD_DONE.
  - In RD_DONE (cycle T+READ_LAT+1): the owner's rvalid is 1 for exactly this cycle, and its rdata shows the captured value and holds afterwards.
  - Arbitration also runs in RD_DONE, so back-to-back accesses are allowed.
  - No grants are issued in RD_WAIT. Minimum read occupancy is READ_LAT+1 cycles.
- Starve counter:
  - Increments (saturating at 15) on each cycle d_req=1 and d_gnt=0.
  - Clears on d_gnt, or on any cycle with d_req=0.
- c_stall = c_req & !(c_gnt & c_we) & !c_rvalid. A core store never stalls when granted immediately.
- Requester rules:
  - req and the request fields must stay stable until gnt.
  - A load requester keeps req high until rvalid.
  - A req asserted in RD_DONE for the port being served counts as a new request.
- Reset asserted mid-read: transaction abandoned, no rvalid, all state returns to reset values immediately.
- Both gnt outputs are never 1 in the same cycle. mem_wr and mem_rd are never both 1.

Test Plan:
- Core store alone: c_req=1, c_we=1, c_addr=0x010, c_wdata=0xDEADBEEF → same cycle c_gnt=1, mem_wr=1, mem_addr=0x010, c_stall=0.
- Core load, READ_LAT=1: grant in cycle T with mem_rd=1; mem_rdata=0x12345678 in T+1 → c_rvalid=1 and c_rdata=0x12345678 in T+2; c_stall=1 in T and T+1, 0 in T+2.
- Contention with STARVE_LIMIT=4: both ports request stores continuously → C granted 4 consecutive cycles, D granted on the 5th, starve_cnt back to 0.
- Back-to-back: core load completes in RD_DONE while d_req=1 (store) → same cycle c_rvalid=1 and d_gnt=1, mem_wr=1.
- READ_LAT=3: D load issued at T → no grants in T+1..T+3 despite c_req=1; d_rvalid at T+4, c_gnt at T+4.
- Reset mid-read: n_rst low during RD_WAIT → next cycles show no rvalid, both rdata outputs 0, state IDLE, and a fresh c_req is granted immediately after release.
